// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared CPU widths, ALU op encoding and issue-queue entry layout
// Register-file and ROB sizes may be overridden with NUM_D_REG / NUM_S_REG / NUM_ROB defines.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif
`ifndef NUM_ROB
`define NUM_ROB 16
`endif

package nand_cpu_pkg;

    localparam int NUM_D_REG = `NUM_D_REG;
    localparam int NUM_S_REG = `NUM_S_REG;
    localparam int NUM_ROB   = `NUM_ROB;
    localparam int D_W       = $clog2(NUM_D_REG);
    localparam int S_W       = $clog2(NUM_S_REG);
    localparam int ROB_W     = $clog2(NUM_ROB);

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NAND, ALU_SHL, ALU_SHR
    } alu_op_t;

    // Everything the execute stage sees for an issued op.
    typedef struct packed {
        logic             use_rt;
        logic [D_W-1:0]   ra_addr;
        logic [D_W-1:0]   rt_addr;
        logic [D_W-1:0]   rw_addr;
        logic [S_W-1:0]   rs_addr;
        logic [ROB_W-1:0] rob_addr;
        logic [3:0]       immdt;
        logic [1:0]       shift;
        alu_op_t          alu_op;
    } iq_payload_t;

    typedef struct packed {
        logic        valid;
        logic        use_ra;
        logic        ra_rdy;
        logic        rt_rdy;
        iq_payload_t pay;
    } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// rtl/iq_select.sv - lowest-index-wins picker: ready vector to one-hot grant, index and any

module iq_select #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/exec_issue_queue.sv
// rtl/exec_issue_queue.sv - compacting oldest-first ALU issue queue with writeback wakeup
// ISSUE_WAKEUP_BYPASS_EN: same-cycle wakeup-to-select; IQ_DISPATCH_ASSERT: flag dispatch while full.
module exec_issue_queue
    import nand_cpu_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               flush,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic                               disp_use_ra,
    input  logic                               disp_use_rt,
    input  logic [D_W-1:0]                     disp_ra_addr,
    input  logic [D_W-1:0]                     disp_rt_addr,
    input  logic                               disp_ra_rdy,
    input  logic                               disp_rt_rdy,
    input  logic [D_W-1:0]                     disp_rw_addr,
    input  logic [S_W-1:0]                     disp_rs_addr,
    input  logic [ROB_W-1:0]                   disp_rob_addr,
    input  logic [3:0]                         disp_immdt,
    input  logic [1:0]                         disp_shift,
    input  alu_op_t                            disp_alu_op,
    input  logic                               wb_valid,
    input  logic [D_W-1:0]                     wb_tag,
    output logic                               iss_valid,
    input  logic                               iss_ready,
    output logic [D_W-1:0]                     iss_ra_addr,
    output logic [D_W-1:0]                     iss_rt_addr,
    output logic                               iss_use_rt,
    output logic [D_W-1:0]                     iss_rw_addr,
    output logic [S_W-1:0]                     iss_rs_addr,
    output logic [ROB_W-1:0]                   iss_rob_addr,
    output logic [3:0]                         iss_immdt,
    output logic [1:0]                         iss_shift,
    output alu_op_t                            iss_alu_op,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    iq_entry_t              ent_q [NUM_ENTRIES];
    iq_entry_t              ent_d [NUM_ENTRIES];
    logic [CNT_W-1:0]       occ_q, occ_d, occ_rem;
    logic [NUM_ENTRIES-1:0] rdy_vec, grant;
    logic [NUM_ENTRIES-1:0] ra_ok, rt_ok;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_any, transfer, accept;
    iq_entry_t              new_ent;
    iq_payload_t            sel_pay;

    always_comb begin
        ra_ok = '0;
        rt_ok = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ra_ok[i] = ent_q[i].ra_rdy;
            rt_ok[i] = ent_q[i].rt_rdy;
`ifdef ISSUE_WAKEUP_BYPASS_EN
            ra_ok[i] = ra_ok[i] | (wb_valid && ent_q[i].pay.ra_addr == wb_tag);
            rt_ok[i] = rt_ok[i] | (wb_valid && ent_q[i].pay.rt_addr == wb_tag);
`endif
        end
    end

    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            rdy_vec[i] = ent_q[i].valid & (!ent_q[i].use_ra | ra_ok[i])
                                        & (!ent_q[i].pay.use_rt | rt_ok[i]);
        end
    end

    iq_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_select (
        .req   (rdy_vec),
        .grant (grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // One-hot AND-OR mux; grant is all-zero when nothing is ready, giving zero outputs.
    always_comb begin
        sel_pay = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) begin
                sel_pay = iq_payload_t'(sel_pay | ent_q[i].pay);
            end
        end
    end

    assign iss_valid    = sel_any;
    assign iss_ra_addr  = sel_pay.ra_addr;
    assign iss_rt_addr  = sel_pay.rt_addr;
    assign iss_use_rt   = sel_pay.use_rt;
    assign iss_rw_addr  = sel_pay.rw_addr;
    assign iss_rs_addr  = sel_pay.rs_addr;
    assign iss_rob_addr = sel_pay.rob_addr;
    assign iss_immdt    = sel_pay.immdt;
    assign iss_shift    = sel_pay.shift;
    assign iss_alu_op   = sel_pay.alu_op;

    assign disp_ready = (occ_q < CNT_W'(NUM_ENTRIES));
    assign occupancy  = occ_q;
    assign transfer   = sel_any & iss_ready;
    assign accept     = disp_valid & disp_ready;
    assign occ_rem    = occ_q - CNT_W'(transfer);

    // Capture a wakeup that arrives in the dispatch cycle so it is never lost.
    always_comb begin
        new_ent              = '0;
        new_ent.valid        = 1'b1;
        new_ent.use_ra       = disp_use_ra;
        new_ent.ra_rdy       = disp_ra_rdy | (wb_valid && disp_ra_addr == wb_tag);
        new_ent.rt_rdy       = disp_rt_rdy | (wb_valid && disp_rt_addr == wb_tag);
        new_ent.pay.use_rt   = disp_use_rt;
        new_ent.pay.ra_addr  = disp_ra_addr;
        new_ent.pay.rt_addr  = disp_rt_addr;
        new_ent.pay.rw_addr  = disp_rw_addr;
        new_ent.pay.rs_addr  = disp_rs_addr;
        new_ent.pay.rob_addr = disp_rob_addr;
        new_ent.pay.immdt    = disp_immdt;
        new_ent.pay.shift    = disp_shift;
        new_ent.pay.alu_op   = disp_alu_op;
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (transfer) begin
            for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    ent_d[i] = ent_q[i+1];
                end
            end
            ent_d[NUM_ENTRIES-1] = '0;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wb_valid && ent_d[i].valid) begin
                if (ent_d[i].pay.ra_addr == wb_tag) ent_d[i].ra_rdy = 1'b1;
                if (ent_d[i].pay.rt_addr == wb_tag) ent_d[i].rt_rdy = 1'b1;
            end
        end
        if (accept) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (i == int'(occ_rem)) ent_d[i] = new_ent;
            end
        end
        occ_d = occ_rem + CNT_W'(accept);
        if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_d[i] = '0;
            end
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
            occ_q <= occ_d;
        end
    end

`ifdef IQ_DISPATCH_ASSERT
    always @(posedge clk) begin
        if (n_rst) begin
            assert (!(disp_valid && !disp_ready))
                else $error("dispatch presented while queue full");
        end
    end
`endif

endmodule

// File: tb/tb_exec_issue_queue.sv
// tb/tb_exec_issue_queue.sv - queue-model scoreboard plus directed literal checks for exec_issue_queue
module tb_exec_issue_queue;
    import nand_cpu_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0, n_rst = 1'b1, flush = 1'b0;
    logic disp_valid = 1'b0, disp_ready;
    logic disp_use_ra = 1'b0, disp_use_rt = 1'b0, disp_ra_rdy = 1'b0, disp_rt_rdy = 1'b0;
    logic [D_W-1:0] disp_ra_addr = '0, disp_rt_addr = '0, disp_rw_addr = '0;
    logic [S_W-1:0] disp_rs_addr = '0;
    logic [ROB_W-1:0] disp_rob_addr = '0;
    logic [3:0] disp_immdt = '0;
    logic [1:0] disp_shift = '0;
    alu_op_t disp_alu_op = ALU_ADD;
    logic wb_valid = 1'b0;
    logic [D_W-1:0] wb_tag = '0;
    logic iss_valid, iss_ready = 1'b0, iss_use_rt;
    logic [D_W-1:0] iss_ra_addr, iss_rt_addr, iss_rw_addr;
    logic [S_W-1:0] iss_rs_addr;
    logic [ROB_W-1:0] iss_rob_addr;
    logic [3:0] iss_immdt;
    logic [1:0] iss_shift;
    alu_op_t iss_alu_op;
    logic [$clog2(N+1)-1:0] occupancy;

    exec_issue_queue #(.NUM_ENTRIES(N)) dut (
        .clk(clk), .n_rst(n_rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_use_ra(disp_use_ra), .disp_use_rt(disp_use_rt),
        .disp_ra_addr(disp_ra_addr), .disp_rt_addr(disp_rt_addr),
        .disp_ra_rdy(disp_ra_rdy), .disp_rt_rdy(disp_rt_rdy),
        .disp_rw_addr(disp_rw_addr), .disp_rs_addr(disp_rs_addr), .disp_rob_addr(disp_rob_addr),
        .disp_immdt(disp_immdt), .disp_shift(disp_shift), .disp_alu_op(disp_alu_op),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ra_addr(iss_ra_addr), .iss_rt_addr(iss_rt_addr), .iss_use_rt(iss_use_rt),
        .iss_rw_addr(iss_rw_addr), .iss_rs_addr(iss_rs_addr), .iss_rob_addr(iss_rob_addr),
        .iss_immdt(iss_immdt), .iss_shift(iss_shift), .iss_alu_op(iss_alu_op),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit use_ra, ra_rdy, use_rt, rt_rdy;
        int ra, rt, rw, rs, rob, immdt, shift, op;
    } m_ent_t;

    m_ent_t mq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_src_ok(bit use_s, bit rdy, int tag);
        bit r = rdy;
`ifdef ISSUE_WAKEUP_BYPASS_EN
        if (wb_valid && tag == int'(wb_tag)) r = 1'b1;
`endif
        return !use_s || r;
    endfunction

    function automatic int m_sel();
        for (int i = 0; i < mq.size(); i++) begin
            if (m_src_ok(mq[i].use_ra, mq[i].ra_rdy, mq[i].ra) &&
                m_src_ok(mq[i].use_rt, mq[i].rt_rdy, mq[i].rt)) return i;
        end
        return -1;
    endfunction

    // Age-ordered list: the front is the oldest op.
    always @(posedge clk or negedge n_rst) begin : model_upd
        int s;
        bit acc;
        m_ent_t e;
        if (!n_rst || flush) begin
            mq.delete();
        end else begin
            s   = m_sel();
            acc = disp_valid && (mq.size() < N);
            if (s >= 0 && iss_ready) mq.delete(s);
            if (wb_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].ra == int'(wb_tag)) mq[i].ra_rdy = 1'b1;
                    if (mq[i].rt == int'(wb_tag)) mq[i].rt_rdy = 1'b1;
                end
            end
            if (acc) begin
                e.use_ra = disp_use_ra;  e.ra = int'(disp_ra_addr);
                e.use_rt = disp_use_rt;  e.rt = int'(disp_rt_addr);
                e.ra_rdy = disp_ra_rdy || (wb_valid && disp_ra_addr == wb_tag);
                e.rt_rdy = disp_rt_rdy || (wb_valid && disp_rt_addr == wb_tag);
                e.rw = int'(disp_rw_addr);  e.rs = int'(disp_rs_addr);
                e.rob = int'(disp_rob_addr); e.immdt = int'(disp_immdt);
                e.shift = int'(disp_shift); e.op = int'(disp_alu_op);
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        int s;
        logic [63:0] exp_pay, act_pay;
        s = m_sel();
        act_pay = 64'({iss_ra_addr, iss_rt_addr, iss_use_rt, iss_rw_addr, iss_rs_addr,
                       iss_rob_addr, iss_immdt, iss_shift, iss_alu_op});
        exp_pay = '0;
        if (s >= 0) begin
            exp_pay = 64'({D_W'(mq[s].ra), D_W'(mq[s].rt), 1'(mq[s].use_rt), D_W'(mq[s].rw),
                           S_W'(mq[s].rs), ROB_W'(mq[s].rob), 4'(mq[s].immdt),
                           2'(mq[s].shift), 3'(mq[s].op)});
        end
        chk("cyc_iss_valid", 64'(iss_valid), 64'(s >= 0));
        chk("cyc_occupancy", 64'(occupancy), 64'(mq.size()));
        chk("cyc_disp_ready", 64'(disp_ready), 64'(mq.size() < N));
        chk("cyc_iss_payload", act_pay, exp_pay);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        disp_valid = 1'b0;
        wb_valid   = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input bit ura, input int ra, input bit rar,
                        input bit urt, input int rt, input bit rtr, input int rob);
        disp_valid    = 1'b1;
        disp_use_ra   = ura;  disp_ra_addr = D_W'(ra);  disp_ra_rdy = rar;
        disp_use_rt   = urt;  disp_rt_addr = D_W'(rt);  disp_rt_rdy = rtr;
        disp_rob_addr = ROB_W'(rob);
        disp_rw_addr  = D_W'(rob + 17);
        disp_rs_addr  = S_W'(rob % 8);
        disp_immdt    = 4'(15 - rob);
        disp_shift    = 2'(rob % 4);
        disp_alu_op   = alu_op_t'(3'(rob % 8));
    endtask

    task automatic wake(input int tag);
        wb_valid = 1'b1;
        wb_tag   = D_W'(tag);
    endtask

    initial begin
        #1 n_rst = 1'b0;
        tick();
        tick();
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_iss_valid", 64'(iss_valid), 64'd0);
        chk("rst_iss_rob", 64'(iss_rob_addr), 64'd0);
        n_rst = 1'b1;
        tick();

        // 1: single ready op issues the cycle after dispatch
        iss_ready = 1'b0;
        disp(1, 5, 1, 1, 6, 1, 3);
        tick();
        chk("t1_iss_valid", 64'(iss_valid), 64'd1);
        chk("t1_iss_ra", 64'(iss_ra_addr), 64'd5);
        chk("t1_iss_rob", 64'(iss_rob_addr), 64'd3);
        chk("t1_iss_rw", 64'(iss_rw_addr), 64'd20);
        iss_ready = 1'b1;
        tick();
        chk("t1_occ_after", 64'(occupancy), 64'd0);

        // 2: younger ready op overtakes; wakeup latency depends on bypass
        iss_ready = 1'b0;
        disp(1, 7, 0, 0, 0, 0, 1);
        tick();
        disp(0, 0, 0, 0, 0, 0, 2);
        tick();
        chk("t2_first_rob", 64'(iss_rob_addr), 64'd2);
        iss_ready = 1'b1;
        tick();
        chk("t2_occ", 64'(occupancy), 64'd1);
        chk("t2_wait_valid", 64'(iss_valid), 64'd0);
        wake(7);
        #1;
`ifdef ISSUE_WAKEUP_BYPASS_EN
        chk("t2_bypass_valid", 64'(iss_valid), 64'd1);
        tick();
        chk("t2_bypass_occ", 64'(occupancy), 64'd0);
`else
        chk("t2_nobypass_valid", 64'(iss_valid), 64'd0);
        tick();
        chk("t2_woken_valid", 64'(iss_valid), 64'd1);
        chk("t2_woken_rob", 64'(iss_rob_addr), 64'd1);
        tick();
        chk("t2_drain_occ", 64'(occupancy), 64'd0);
`endif

        // 3: fill, refuse when full even with a same-cycle issue
        iss_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            disp(0, 0, 1, 0, 0, 1, i);
            tick();
        end
        chk("t3_full_occ", 64'(occupancy), 64'd8);
        chk("t3_full_ready", 64'(disp_ready), 64'd0);
        disp(0, 0, 1, 0, 0, 1, 15);
        tick();
        chk("t3_extra_occ", 64'(occupancy), 64'd8);
        chk("t3_head_rob", 64'(iss_rob_addr), 64'd0);
        iss_ready = 1'b1;
        disp(0, 0, 1, 0, 0, 1, 9);
        tick();
        chk("t3_full_issue_occ", 64'(occupancy), 64'd7);
        chk("t3_next_head", 64'(iss_rob_addr), 64'd1);
        disp(0, 0, 1, 0, 0, 1, 10);
        tick();
        chk("t3_disp_iss_occ", 64'(occupancy), 64'd7);
        for (int i = 0; i < 7; i++) tick();
        chk("t3_drained", 64'(occupancy), 64'd0);

        // 4: wakeup coinciding with dispatch is captured
        iss_ready = 1'b1;
        disp(1, 9, 0, 0, 0, 1, 7);
        wake(9);
        tick();
        chk("t4_valid", 64'(iss_valid), 64'd1);
        chk("t4_rob", 64'(iss_rob_addr), 64'd7);
        tick();
        chk("t4_occ", 64'(occupancy), 64'd0);

        // 5: flush dominates dispatch and issue
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(0, 0, 1, 0, 0, 1, i);
            tick();
        end
        iss_ready = 1'b1;
        flush = 1'b1;
        disp(0, 0, 1, 0, 0, 1, 4);
        tick();
        chk("t5_occ", 64'(occupancy), 64'd0);
        chk("t5_valid", 64'(iss_valid), 64'd0);

        // 6: middle entry leaves first, survivors keep age order
        iss_ready = 1'b0;
        disp(1, 11, 0, 0, 0, 1, 4);
        tick();
        disp(0, 0, 1, 0, 0, 1, 5);
        tick();
        disp(1, 12, 0, 0, 0, 1, 6);
        tick();
        chk("t6_mid_rob", 64'(iss_rob_addr), 64'd5);
        iss_ready = 1'b1;
        tick();
        chk("t6_occ2", 64'(occupancy), 64'd2);
        iss_ready = 1'b0;
        wake(12);
        tick();
        wake(11);
        tick();
        chk("t6_oldest_rob", 64'(iss_rob_addr), 64'd4);
        iss_ready = 1'b1;
        tick();
        chk("t6_second_rob", 64'(iss_rob_addr), 64'd6);
        tick();
        chk("t6_occ0", 64'(occupancy), 64'd0);

        // mid-stream asynchronous reset
        iss_ready = 1'b0;
        disp(1, 3, 1, 1, 4, 1, 8);
        tick();
        disp(0, 0, 1, 0, 0, 1, 9);
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_occ", 64'(occupancy), 64'd0);
        chk("rst_mid_valid", 64'(iss_valid), 64'd0);
        chk("rst_mid_ready", 64'(disp_ready), 64'd1);
        chk("rst_mid_ra", 64'(iss_ra_addr), 64'd0);
        tick();
        n_rst = 1'b1;
        iss_ready = 1'b1;
        disp(0, 0, 1, 0, 0, 1, 12);
        tick();
        chk("post_rst_rob", 64'(iss_rob_addr), 64'd12);
        tick();
        chk("post_rst_occ", 64'(occupancy), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
